// File: rtl/pipeline_bus_arbiter.sv
// pipeline_bus_arbiter
// Hands the memory bus to an external bus master (DMA) while keeping the CPU
// pipeline coherent: fetch is suppressed while in-flight stages drain, the
// pipeline is frozen during the grant, and one turnaround cycle follows every
// grant. Grants can be capped in length, and a capped grant is followed by a
// guaranteed CPU window during which new requests are ignored.
//
// Optional build macro: PIPE_ARB_STATS_EN adds the GrantCycles / PreemptCount
// statistics outputs. Without it those ports and counters are absent.
module pipeline_bus_arbiter #(
    parameter int DRAIN_CYCLES   = 3,
    parameter int MAX_GRANT      = 64,
    parameter int MIN_CPU_CYCLES = 8
) (
    input  logic        ClockIn,
    input  logic        Reset,
    input  logic        BusRequest,
    input  logic        FetchSurpressIn,
    output logic        FetchSurpress,
    output logic        PipeHold,
    output logic        BusGrant,
    output logic        Preempted
`ifdef PIPE_ARB_STATS_EN
    ,
    output logic [15:0] GrantCycles,
    output logic [7:0]  PreemptCount
`endif
);

    localparam logic [2:0] ST_RUN      = 3'd0;
    localparam logic [2:0] ST_DRAIN    = 3'd1;
    localparam logic [2:0] ST_GRANT    = 3'd2;
    localparam logic [2:0] ST_RELEASE  = 3'd3;
    localparam logic [2:0] ST_COOLDOWN = 3'd4;

    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES);
    localparam logic [7:0] COOL_LOAD  = 8'(MIN_CPU_CYCLES);
    localparam logic [7:0] GRANT_LAST = 8'(MAX_GRANT - 1);
    localparam bit         GRANT_CAPPED = (MAX_GRANT != 0);

    logic [2:0] state_reg, state_next;
    logic [7:0] drain_cnt_reg, drain_cnt_next;
    logic [7:0] grant_cnt_reg, grant_cnt_next;
    logic [7:0] cool_cnt_reg, cool_cnt_next;
    logic       preempt_reg, preempt_next;
    logic       preempt_pulse;

    logic       arb_suppress_reg;
    logic       pipe_hold_reg;
    logic       bus_grant_reg;
    logic       preempted_reg;

    // Next-state and counter logic for the drain / grant / release sequence
    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        grant_cnt_next = grant_cnt_reg;
        cool_cnt_next  = cool_cnt_reg;
        preempt_next   = preempt_reg;
        preempt_pulse  = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (BusRequest) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                // Losing the request aborts before any grant is issued.
                if (!BusRequest) begin
                    state_next = ST_RELEASE;
                end else if (drain_cnt_reg <= 8'd1) begin
                    state_next     = ST_GRANT;
                    grant_cnt_next = 8'd0;
                end else begin
                    drain_cnt_next = drain_cnt_reg - 8'd1;
                end
            end
            ST_GRANT: begin
                // A voluntary release on the last allowed cycle wins over preemption.
                if (!BusRequest) begin
                    state_next = ST_RELEASE;
                end else if (GRANT_CAPPED && (grant_cnt_reg == GRANT_LAST)) begin
                    state_next    = ST_RELEASE;
                    preempt_next  = 1'b1;
                    preempt_pulse = 1'b1;
                end else if (grant_cnt_reg != 8'hFF) begin
                    grant_cnt_next = grant_cnt_reg + 8'd1;
                end
            end
            ST_RELEASE: begin
                preempt_next = 1'b0;
                if (preempt_reg) begin
                    state_next    = ST_COOLDOWN;
                    cool_cnt_next = COOL_LOAD;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_COOLDOWN: begin
                if (cool_cnt_reg <= 8'd1) begin
                    state_next = ST_RUN;
                end else begin
                    cool_cnt_next = cool_cnt_reg - 8'd1;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // State, counters and registered outputs decoded from the next state
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_reg        <= ST_RUN;
            drain_cnt_reg    <= 8'd0;
            grant_cnt_reg    <= 8'd0;
            cool_cnt_reg     <= 8'd0;
            preempt_reg      <= 1'b0;
            arb_suppress_reg <= 1'b0;
            pipe_hold_reg    <= 1'b0;
            bus_grant_reg    <= 1'b0;
            preempted_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            drain_cnt_reg    <= drain_cnt_next;
            grant_cnt_reg    <= grant_cnt_next;
            cool_cnt_reg     <= cool_cnt_next;
            preempt_reg      <= preempt_next;
            arb_suppress_reg <= (state_next == ST_DRAIN) || (state_next == ST_GRANT) ||
                                (state_next == ST_RELEASE);
            pipe_hold_reg    <= (state_next == ST_GRANT) || (state_next == ST_RELEASE);
            bus_grant_reg    <= (state_next == ST_GRANT);
            preempted_reg    <= preempt_pulse;
        end
    end

    assign FetchSurpress = FetchSurpressIn | arb_suppress_reg;
    assign PipeHold      = pipe_hold_reg;
    assign BusGrant      = bus_grant_reg;
    assign Preempted     = preempted_reg;

`ifdef PIPE_ARB_STATS_EN
    logic [15:0] grant_cycles_reg;
    logic [7:0]  preempt_count_reg;

    // Saturating statistics, cleared only by reset
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            grant_cycles_reg  <= 16'd0;
            preempt_count_reg <= 8'd0;
        end else begin
            if (bus_grant_reg && (grant_cycles_reg != 16'hFFFF)) begin
                grant_cycles_reg <= grant_cycles_reg + 16'd1;
            end
            if (preempted_reg && (preempt_count_reg != 8'hFF)) begin
                preempt_count_reg <= preempt_count_reg + 8'd1;
            end
        end
    end

    assign GrantCycles  = grant_cycles_reg;
    assign PreemptCount = preempt_count_reg;
`endif

endmodule

// File: tb/tb_pipeline_bus_arbiter.sv
// tb_pipeline_bus_arbiter
// Two arbiters share reset and FetchSurpressIn: dut_a uses default parameters,
// dut_b caps grants at 4 cycles. Each stimulus row drives one cycle's inputs and
// queues the outputs expected in that same cycle; a negedge monitor pops and
// compares. Expected vectors are {FetchSurpress, PipeHold, BusGrant, Preempted}.
module tb_pipeline_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic fsi = 1'b0;
    logic req_a = 1'b0;
    logic req_b = 1'b0;
    logic fs_a, ph_a, bg_a, pe_a;
    logic fs_b, ph_b, bg_b, pe_b;
`ifdef PIPE_ARB_STATS_EN
    logic [15:0] gc_a, gc_b;
    logic [7:0]  pc_a, pc_b;
`endif

    pipeline_bus_arbiter dut_a (
        .ClockIn        (clk),
        .Reset          (rst),
        .BusRequest     (req_a),
        .FetchSurpressIn(fsi),
        .FetchSurpress  (fs_a),
        .PipeHold       (ph_a),
        .BusGrant       (bg_a),
        .Preempted      (pe_a)
`ifdef PIPE_ARB_STATS_EN
        ,
        .GrantCycles    (gc_a),
        .PreemptCount   (pc_a)
`endif
    );

    pipeline_bus_arbiter #(.DRAIN_CYCLES(3), .MAX_GRANT(4), .MIN_CPU_CYCLES(8)) dut_b (
        .ClockIn        (clk),
        .Reset          (rst),
        .BusRequest     (req_b),
        .FetchSurpressIn(fsi),
        .FetchSurpress  (fs_b),
        .PipeHold       (ph_b),
        .BusGrant       (bg_b),
        .Preempted      (pe_b)
`ifdef PIPE_ARB_STATS_EN
        ,
        .GrantCycles    (gc_b),
        .PreemptCount   (pc_b)
`endif
    );

    localparam logic [3:0] IDLE = 4'b0000;
    localparam logic [3:0] SUPP = 4'b1000;
    localparam logic [3:0] GNT  = 4'b1110;
    localparam logic [3:0] REL  = 4'b1100;
    localparam logic [3:0] RELP = 4'b1101;

    typedef struct {
        string      tag;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // One row per cycle: drive inputs just after the edge and queue that cycle's outputs
    task automatic cyc(input int n, input logic r, input logic ra, input logic rb,
                       input logic f, input logic [3:0] ea, input logic [3:0] eb,
                       input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst   = r;
            req_a = ra;
            req_b = rb;
            fsi   = f;
            e.tag   = tag;
            e.exp_a = ea;
            e.exp_b = eb;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compare both arbiters mid-cycle against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [3:0] got_a;
            logic [3:0] got_b;
            e = exp_q.pop_front();
            got_a = {fs_a, ph_a, bg_a, pe_a};
            got_b = {fs_b, ph_b, bg_b, pe_b};
            checks++;
            if (got_a !== e.exp_a) begin
                errors++;
                $display("FAIL %s dut_a got=%b want=%b", e.tag, got_a, e.exp_a);
            end
            checks++;
            if (got_b !== e.exp_b) begin
                errors++;
                $display("FAIL %s dut_b got=%b want=%b", e.tag, got_b, e.exp_b);
            end
            $display("cycle %s a=%b b=%b", e.tag, got_a, got_b);
        end
    end

`ifdef PIPE_ARB_STATS_EN
    task automatic check_stats(input string tag, input logic [15:0] gc, input logic [15:0] gc_want,
                               input logic [7:0] pc, input logic [7:0] pc_want);
        @(negedge clk);
        checks++;
        if (gc !== gc_want) begin
            errors++;
            $display("FAIL %s GrantCycles got=%0d want=%0d", tag, gc, gc_want);
        end
        checks++;
        if (pc !== pc_want) begin
            errors++;
            $display("FAIL %s PreemptCount got=%0d want=%0d", tag, pc, pc_want);
        end
    endtask
`endif

    initial begin
        // Reset, idle, and combinational fetch-suppress pass-through in RUN
        cyc(2, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, IDLE, "reset");
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, IDLE, "idle");
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, SUPP, SUPP, "fsi_pass");

        // dut_a: request, 3 drain cycles, 5 grant cycles, one release, back to RUN
        cyc(1, 1'b0, 1'b1, 1'b0, 1'b0, IDLE, IDLE, "a_req");
        cyc(3, 1'b0, 1'b1, 1'b0, 1'b0, SUPP, IDLE, "a_drain");
        cyc(4, 1'b0, 1'b1, 1'b0, 1'b0, GNT,  IDLE, "a_grant");
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, GNT,  IDLE, "a_grant_last");
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, REL,  IDLE, "a_release");
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, IDLE, "a_run");
`ifdef PIPE_ARB_STATS_EN
        check_stats("a_stats", gc_a, 16'd5, pc_a, 8'd0);
`endif

        // dut_b: held request is preempted after 4 grants, 8 cooldown cycles ignore it
        cyc(1, 1'b0, 1'b0, 1'b1, 1'b0, IDLE, IDLE, "b_req");
        cyc(3, 1'b0, 1'b0, 1'b1, 1'b0, IDLE, SUPP, "b_drain");
        cyc(4, 1'b0, 1'b0, 1'b1, 1'b0, IDLE, GNT,  "b_grant");
        cyc(1, 1'b0, 1'b0, 1'b1, 1'b0, IDLE, RELP, "b_preempt");
        cyc(8, 1'b0, 1'b0, 1'b1, 1'b0, IDLE, IDLE, "b_cooldown");
        cyc(1, 1'b0, 1'b0, 1'b1, 1'b0, IDLE, IDLE, "b_run");
        // Re-entry into DRAIN, then abort in the second drain cycle
        cyc(1, 1'b0, 1'b0, 1'b1, 1'b0, IDLE, SUPP, "b_redrain");
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, SUPP, "b_abort");
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, REL,  "b_abort_rel");
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, IDLE, "b_run2");
`ifdef PIPE_ARB_STATS_EN
        check_stats("b_stats", gc_b, 16'd4, pc_b, 8'd1);
`endif

        // dut_a: reset held two cycles in the middle of a grant
        cyc(1, 1'b0, 1'b1, 1'b0, 1'b0, IDLE, IDLE, "a2_req");
        cyc(3, 1'b0, 1'b1, 1'b0, 1'b0, SUPP, IDLE, "a2_drain");
        cyc(1, 1'b0, 1'b1, 1'b0, 1'b0, GNT,  IDLE, "a2_grant");
        cyc(1, 1'b1, 1'b1, 1'b0, 1'b0, GNT,  IDLE, "a2_rst_edge");
        cyc(1, 1'b1, 1'b1, 1'b0, 1'b0, IDLE, IDLE, "a2_rst_hold");
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, IDLE, "a2_after_rst");
`ifdef PIPE_ARB_STATS_EN
        check_stats("a2_stats", gc_a, 16'd0, pc_a, 8'd0);
`endif

        // dut_a after reset: full drain length again, one grant with fetch-suppress input high
        cyc(1, 1'b0, 1'b1, 1'b0, 1'b0, IDLE, IDLE, "a3_req");
        cyc(3, 1'b0, 1'b1, 1'b0, 1'b0, SUPP, IDLE, "a3_drain");
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, GNT,  SUPP, "a3_grant_fsi");
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, REL,  IDLE, "a3_release");
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, IDLE, "a3_run");

        // Let the monitor consume every queued row, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue pending=%0d want=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
